// File: rtl/spm_ctrl_pkg.sv
// Shared constants, saturation helper and adjuster channel indices for the
// SPM scan/offset control stage.
package spm_ctrl_pkg;

  localparam int DW_DEF     = 32;
  localparam int QROTM_DEF  = 28;
  localparam int QSLOPE_DEF = 31;

  localparam logic signed [31:0] MAXPOS = 32'sh7FFF_FFFF;

  // Bit positions inside the settled vector; aux channels start at IDX_AUX.
  localparam int IDX_X0  = 0;
  localparam int IDX_Y0  = 1;
  localparam int IDX_Z0  = 2;
  localparam int IDX_DZX = 3;
  localparam int IDX_DZY = 4;
  localparam int IDX_AUX = 5;

  // Symmetric clamp to +/-(2^31-1); -2^31 is never produced.
  function automatic logic signed [31:0] sat32(input logic signed [35:0] v);
    if (v > 36'sh0_7FFF_FFFF)
      return MAXPOS;
    else if (v < -36'sh0_7FFF_FFFF)
      return -MAXPOS;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/spm_slew_adjuster.sv
// One slew-limited register: on each tick moves cur toward tgt by at most
// step (bit DW-1 of step ignored), saturating, and flags when it has arrived.
module spm_slew_adjuster
  import spm_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          a_clk,
  input  logic          a_rst,
  input  logic          tick,
  input  logic [DW-1:0] tgt,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] cur,
  output logic          settled
);

  logic [DW-1:0]        r_cur;
  logic                 r_settled;
  logic [DW-1:0]        w_step_mag;
  logic signed [DW:0]   w_p;
  logic signed [DW:0]   w_m;
  logic signed [DW:0]   w_tgt;
  logic [DW-1:0]        w_next;

  assign w_step_mag = step & {1'b0, {(DW-1){1'b1}}};

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    w_p    = $signed({r_cur[DW-1], r_cur}) + $signed({1'b0, w_step_mag});
    w_m    = $signed({r_cur[DW-1], r_cur}) - $signed({1'b0, w_step_mag});
    w_tgt  = $signed({tgt[DW-1], tgt});
    w_next = tgt;
    if (w_tgt > w_p)
      w_next = sat32(36'(w_p));
    else if (w_tgt < w_m)
      w_next = sat32(36'(w_m));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_cur     <= '0;
      r_settled <= 1'b0;
    end else if (tick) begin
      r_cur     <= w_next;
      r_settled <= (w_next == tgt);
    end
  end

  assign cur     = r_cur;
  assign settled = r_settled;

endmodule

// File: rtl/axis_spm_control_v2.sv
// SPM scan/offset control: rotates the scan vector, adds slewed offsets and
// plane compensation, and drives the X/Y/Z/U and aux DAC streams.
module axis_spm_control_v2
  import spm_ctrl_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int QROTM  = QROTM_DEF,
  parameter int QSLOPE = QSLOPE_DEF,
  parameter int RDECI  = 5,
  parameter int NAUX   = 2
) (
  input  logic                 a_clk,
  input  logic                 a_rst,
  input  logic [DW-1:0]        S_AXIS_Xs_tdata,
  input  logic                 S_AXIS_Xs_tvalid,
  input  logic [DW-1:0]        S_AXIS_Ys_tdata,
  input  logic                 S_AXIS_Ys_tvalid,
  input  logic [DW-1:0]        S_AXIS_Zs_tdata,
  input  logic                 S_AXIS_Zs_tvalid,
  input  logic [DW-1:0]        S_AXIS_Z_tdata,
  input  logic                 S_AXIS_Z_tvalid,
  input  logic [DW-1:0]        S_AXIS_U_tdata,
  input  logic                 S_AXIS_U_tvalid,
  input  logic [DW-1:0]        rotmxx,
  input  logic [DW-1:0]        rotmxy,
  input  logic [DW-1:0]        slope_x,
  input  logic [DW-1:0]        slope_y,
  input  logic                 slope_en,
  input  logic [DW-1:0]        x0,
  input  logic [DW-1:0]        y0,
  input  logic [DW-1:0]        z0,
  input  logic [DW-1:0]        u0,
  input  logic [NAUX*DW-1:0]   aux0,
  input  logic [DW-1:0]        xy_offset_step,
  input  logic [DW-1:0]        z_offset_step,
  input  logic [DW-1:0]        aux_step,
  output logic [DW-1:0]        M_AXIS1_tdata,
  output logic                 M_AXIS1_tvalid,
  output logic [DW-1:0]        M_AXIS2_tdata,
  output logic                 M_AXIS2_tvalid,
  output logic [DW-1:0]        M_AXIS3_tdata,
  output logic                 M_AXIS3_tvalid,
  output logic [DW-1:0]        M_AXIS4_tdata,
  output logic                 M_AXIS4_tvalid,
  output logic [NAUX*DW-1:0]   M_AXIS_AUX_tdata,
  output logic                 M_AXIS_AUX_tvalid,
  output logic [DW-1:0]        M_AXIS_X0MON_tdata,
  output logic                 M_AXIS_X0MON_tvalid,
  output logic [DW-1:0]        M_AXIS_Y0MON_tdata,
  output logic                 M_AXIS_Y0MON_tvalid,
  output logic [DW-1:0]        M_AXIS_Z0MON_tdata,
  output logic                 M_AXIS_Z0MON_tvalid,
  output logic [DW-1:0]        M_AXIS_Z_SLOPE_tdata,
  output logic                 M_AXIS_Z_SLOPE_tvalid,
  output logic [4+NAUX:0]      settled
);

  localparam int NADJ = 5 + NAUX;
  localparam int CW   = RDECI + 1;
  localparam int RRW  = DW + QROTM + 2;
  localparam int MW   = 2 * DW;
  localparam int ZW   = DW + 2;
  localparam int PW   = 2 * DW + 2;
  localparam logic [CW-1:0] DECI_LAST = CW'((1 << RDECI) - 1);

  // Decimation: wraps at 2^RDECI-1 so RDECI=0 ticks on every clock.
  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == '0);

  always_ff @(posedge a_clk) begin
    if (a_rst)
      r_cnt <= '0;
    else
      r_cnt <= (r_cnt == DECI_LAST) ? '0 : r_cnt + CW'(1);
  end

  logic signed [DW-1:0] r_xs, r_ys, r_zs, r_z, r_u, r_mxx, r_mxy, r_u0;
  logic                 r_slope_en;

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_xs       <= '0;
      r_ys       <= '0;
      r_zs       <= '0;
      r_z        <= '0;
      r_u        <= '0;
      r_mxx      <= '0;
      r_mxy      <= '0;
      r_u0       <= '0;
      r_slope_en <= 1'b0;
    end else if (w_tick) begin
      if (S_AXIS_Xs_tvalid) r_xs <= S_AXIS_Xs_tdata;
      if (S_AXIS_Ys_tvalid) r_ys <= S_AXIS_Ys_tdata;
      if (S_AXIS_Zs_tvalid) r_zs <= S_AXIS_Zs_tdata;
      if (S_AXIS_Z_tvalid)  r_z  <= S_AXIS_Z_tdata;
      if (S_AXIS_U_tvalid)  r_u  <= S_AXIS_U_tdata;
      r_mxx      <= rotmxx;
      r_mxy      <= rotmxy;
      r_u0       <= u0;
      r_slope_en <= slope_en;
    end
  end

  logic [DW-1:0]   w_tgt  [NADJ];
  logic [DW-1:0]   w_step [NADJ];
  logic [DW-1:0]   w_cur  [NADJ];
  logic [NADJ-1:0] w_settled;

  always_comb begin
    for (int k = 0; k < NADJ; k++) begin
      w_tgt[k]  = '0;
      w_step[k] = '0;
    end
    w_tgt[IDX_X0]   = x0;
    w_tgt[IDX_Y0]   = y0;
    w_tgt[IDX_Z0]   = z0;
    w_tgt[IDX_DZX]  = slope_x;
    w_tgt[IDX_DZY]  = slope_y;
    w_step[IDX_X0]  = xy_offset_step;
    w_step[IDX_Y0]  = xy_offset_step;
    w_step[IDX_Z0]  = xy_offset_step;
    w_step[IDX_DZX] = z_offset_step;
    w_step[IDX_DZY] = z_offset_step;
    for (int k = 0; k < NAUX; k++) begin
      w_tgt[IDX_AUX+k]  = aux0[k*DW +: DW];
      w_step[IDX_AUX+k] = aux_step;
    end
  end

  for (genvar g = 0; g < NADJ; g++) begin : g_adj
    spm_slew_adjuster #(.DW(DW)) u_adj (
      .a_clk   (a_clk),
      .a_rst   (a_rst),
      .tick    (w_tick),
      .tgt     (w_tgt[g]),
      .step    (w_step[g]),
      .cur     (w_cur[g]),
      .settled (w_settled[g])
    );
  end

  // Rotation products; offsets, Z terms and slopes travel alongside so each
  // output combines values captured on the same tick.
  logic signed [MW-1:0]  w_pa, w_pb, w_pc, w_pd;
  logic signed [RRW-1:0] r_rrx, r_rry;
  logic signed [DW-1:0]  r_s1_mx0, r_s1_my0, r_s1_dzx, r_s1_dzy, r_s2_dzx, r_s2_dzy;
  logic signed [ZW-1:0]  r_s1_zbase, r_s2_zbase, r_s3_zbase, r_s4_zbase;
  logic signed [DW:0]    r_s1_ub, r_s2_ub;
  logic                  r_s1_en, r_s2_en, r_s3_en, r_s4_en;
  logic signed [ZW-1:0]  r_rx, r_ry, r_zslope;
  logic signed [PW-1:0]  r_pzx, r_pzy;
  logic signed [DW-1:0]  r_xout, r_yout, r_uout, r_zout;
  logic [5:0]            r_vpipe;

  assign w_pa = MW'(r_mxx) * MW'(r_xs);
  assign w_pb = MW'(r_mxy) * MW'(r_ys);
  assign w_pc = MW'(r_mxy) * MW'(r_xs);
  assign w_pd = MW'(r_mxx) * MW'(r_ys);

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_rrx      <= '0;
      r_rry      <= '0;
      r_s1_mx0   <= '0;
      r_s1_my0   <= '0;
      r_s1_dzx   <= '0;
      r_s1_dzy   <= '0;
      r_s1_zbase <= '0;
      r_s1_ub    <= '0;
      r_s1_en    <= 1'b0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_s2_dzx   <= '0;
      r_s2_dzy   <= '0;
      r_s2_zbase <= '0;
      r_s2_ub    <= '0;
      r_s2_en    <= 1'b0;
      r_xout     <= '0;
      r_yout     <= '0;
      r_uout     <= '0;
      r_pzx      <= '0;
      r_pzy      <= '0;
      r_s3_zbase <= '0;
      r_s3_en    <= 1'b0;
      r_zslope   <= '0;
      r_s4_zbase <= '0;
      r_s4_en    <= 1'b0;
      r_zout     <= '0;
      r_vpipe    <= '0;
    end else begin
      r_rrx      <= RRW'(w_pa + w_pb);
      r_rry      <= RRW'(w_pd - w_pc);
      r_s1_mx0   <= w_cur[IDX_X0];
      r_s1_my0   <= w_cur[IDX_Y0];
      r_s1_dzx   <= w_cur[IDX_DZX];
      r_s1_dzy   <= w_cur[IDX_DZY];
      r_s1_zbase <= ZW'($signed(w_cur[IDX_Z0])) + ZW'(r_zs) + ZW'(r_z);
      r_s1_ub    <= (DW+1)'(r_u0) + (DW+1)'(r_u);
      r_s1_en    <= r_slope_en;

      r_rx       <= ZW'(r_rrx >>> QROTM) + ZW'(r_s1_mx0);
      r_ry       <= ZW'(r_rry >>> QROTM) + ZW'(r_s1_my0);
      r_s2_dzx   <= r_s1_dzx;
      r_s2_dzy   <= r_s1_dzy;
      r_s2_zbase <= r_s1_zbase;
      r_s2_ub    <= r_s1_ub;
      r_s2_en    <= r_s1_en;

      r_xout     <= sat32(36'(r_rx));
      r_yout     <= sat32(36'(r_ry));
      r_uout     <= sat32(36'(r_s2_ub));
      r_pzx      <= PW'(r_s2_dzx) * PW'(r_rx);
      r_pzy      <= PW'(r_s2_dzy) * PW'(r_ry);
      r_s3_zbase <= r_s2_zbase;
      r_s3_en    <= r_s2_en;

      r_zslope   <= ZW'(r_pzx >>> QSLOPE) + ZW'(r_pzy >>> QSLOPE);
      r_s4_zbase <= r_s3_zbase;
      r_s4_en    <= r_s3_en;

      r_zout     <= sat32(36'(r_s4_zbase) + (r_s4_en ? 36'(r_zslope) : 36'sd0));

      // Sticky first-tick marker delayed to line up with the Z output.
      r_vpipe    <= {r_vpipe[4:0], r_vpipe[0] | w_tick};
    end
  end

  always_comb begin
    M_AXIS_AUX_tdata = '0;
    for (int k = 0; k < NAUX; k++)
      M_AXIS_AUX_tdata[k*DW +: DW] = w_cur[IDX_AUX+k];
  end

  assign M_AXIS1_tdata         = r_xout;
  assign M_AXIS2_tdata         = r_yout;
  assign M_AXIS3_tdata         = r_zout;
  assign M_AXIS4_tdata         = r_uout;
  assign M_AXIS_X0MON_tdata    = w_cur[IDX_X0];
  assign M_AXIS_Y0MON_tdata    = w_cur[IDX_Y0];
  assign M_AXIS_Z0MON_tdata    = w_cur[IDX_Z0];
  assign M_AXIS_Z_SLOPE_tdata  = sat32(36'(r_zslope));
  assign settled               = w_settled;

  assign M_AXIS1_tvalid        = r_vpipe[5];
  assign M_AXIS2_tvalid        = r_vpipe[5];
  assign M_AXIS3_tvalid        = r_vpipe[5];
  assign M_AXIS4_tvalid        = r_vpipe[5];
  assign M_AXIS_AUX_tvalid     = r_vpipe[5];
  assign M_AXIS_X0MON_tvalid   = r_vpipe[5];
  assign M_AXIS_Y0MON_tvalid   = r_vpipe[5];
  assign M_AXIS_Z0MON_tvalid   = r_vpipe[5];
  assign M_AXIS_Z_SLOPE_tvalid = r_vpipe[5];

endmodule

// File: tb/tb_axis_spm_control_v2.sv
// Directed bench: one instance at RDECI=0 for function/latency, one at
// RDECI=2 for decimation and held-sample behaviour.
module tb_axis_spm_control_v2;

  localparam int DW   = 32;
  localparam int NAUX = 2;

  logic a_clk = 1'b0;
  logic a_rst = 1'b1;
  always #5 a_clk = ~a_clk;

  logic [DW-1:0]      xs, ys, zs, zz, uu;
  logic               xs_v, ys_v, zs_v, zz_v, uu_v;
  logic [DW-1:0]      rotmxx, rotmxy, slope_x, slope_y;
  logic               slope_en;
  logic [DW-1:0]      x0, y0, z0, u0;
  logic [NAUX*DW-1:0] aux0;
  logic [DW-1:0]      xy_step, z_step, aux_step;

  logic signed [DW-1:0] x_d, y_d, z_d, u_d, x0m, y0m, z0m, zsl;
  logic                 xv, yv, zv, uv, auxv, x0mv, y0mv, z0mv, zslv;
  logic [NAUX*DW-1:0]   aux_d;
  logic [4+NAUX:0]      settled_d;

  logic signed [DW-1:0] x_2, y_2, z_2, u_2, x0m_2, y0m_2, z0m_2, zsl_2;
  logic                 xv_2, yv_2, zv_2, uv_2, auxv_2, x0mv_2, y0mv_2, z0mv_2, zslv_2;
  logic [NAUX*DW-1:0]   aux_2;
  logic [4+NAUX:0]      settled_2;

  axis_spm_control_v2 #(.RDECI(0), .NAUX(NAUX)) dut0 (
    .a_clk(a_clk), .a_rst(a_rst),
    .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(xs_v),
    .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(ys_v),
    .S_AXIS_Zs_tdata(zs), .S_AXIS_Zs_tvalid(zs_v),
    .S_AXIS_Z_tdata(zz),  .S_AXIS_Z_tvalid(zz_v),
    .S_AXIS_U_tdata(uu),  .S_AXIS_U_tvalid(uu_v),
    .rotmxx(rotmxx), .rotmxy(rotmxy), .slope_x(slope_x), .slope_y(slope_y),
    .slope_en(slope_en), .x0(x0), .y0(y0), .z0(z0), .u0(u0), .aux0(aux0),
    .xy_offset_step(xy_step), .z_offset_step(z_step), .aux_step(aux_step),
    .M_AXIS1_tdata(x_d), .M_AXIS1_tvalid(xv),
    .M_AXIS2_tdata(y_d), .M_AXIS2_tvalid(yv),
    .M_AXIS3_tdata(z_d), .M_AXIS3_tvalid(zv),
    .M_AXIS4_tdata(u_d), .M_AXIS4_tvalid(uv),
    .M_AXIS_AUX_tdata(aux_d), .M_AXIS_AUX_tvalid(auxv),
    .M_AXIS_X0MON_tdata(x0m), .M_AXIS_X0MON_tvalid(x0mv),
    .M_AXIS_Y0MON_tdata(y0m), .M_AXIS_Y0MON_tvalid(y0mv),
    .M_AXIS_Z0MON_tdata(z0m), .M_AXIS_Z0MON_tvalid(z0mv),
    .M_AXIS_Z_SLOPE_tdata(zsl), .M_AXIS_Z_SLOPE_tvalid(zslv),
    .settled(settled_d)
  );

  axis_spm_control_v2 #(.RDECI(2), .NAUX(NAUX)) dut2 (
    .a_clk(a_clk), .a_rst(a_rst),
    .S_AXIS_Xs_tdata(xs), .S_AXIS_Xs_tvalid(xs_v),
    .S_AXIS_Ys_tdata(ys), .S_AXIS_Ys_tvalid(ys_v),
    .S_AXIS_Zs_tdata(zs), .S_AXIS_Zs_tvalid(zs_v),
    .S_AXIS_Z_tdata(zz),  .S_AXIS_Z_tvalid(zz_v),
    .S_AXIS_U_tdata(uu),  .S_AXIS_U_tvalid(uu_v),
    .rotmxx(rotmxx), .rotmxy(rotmxy), .slope_x(slope_x), .slope_y(slope_y),
    .slope_en(slope_en), .x0(x0), .y0(y0), .z0(z0), .u0(u0), .aux0(aux0),
    .xy_offset_step(xy_step), .z_offset_step(z_step), .aux_step(aux_step),
    .M_AXIS1_tdata(x_2), .M_AXIS1_tvalid(xv_2),
    .M_AXIS2_tdata(y_2), .M_AXIS2_tvalid(yv_2),
    .M_AXIS3_tdata(z_2), .M_AXIS3_tvalid(zv_2),
    .M_AXIS4_tdata(u_2), .M_AXIS4_tvalid(uv_2),
    .M_AXIS_AUX_tdata(aux_2), .M_AXIS_AUX_tvalid(auxv_2),
    .M_AXIS_X0MON_tdata(x0m_2), .M_AXIS_X0MON_tvalid(x0mv_2),
    .M_AXIS_Y0MON_tdata(y0m_2), .M_AXIS_Y0MON_tvalid(y0mv_2),
    .M_AXIS_Z0MON_tdata(z0m_2), .M_AXIS_Z0MON_tvalid(z0mv_2),
    .M_AXIS_Z_SLOPE_tdata(zsl_2), .M_AXIS_Z_SLOPE_tvalid(zslv_2),
    .settled(settled_2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  initial begin
    xs = 32'd1000; ys = -32'sd500; zs = '0; zz = '0; uu = -32'sd10;
    xs_v = 1'b1; ys_v = 1'b1; zs_v = 1'b1; zz_v = 1'b1; uu_v = 1'b1;
    rotmxx = 32'd1 << 28; rotmxy = '0; slope_x = '0; slope_y = '0; slope_en = 1'b0;
    x0 = '0; y0 = '0; z0 = '0; u0 = 32'd7; aux0 = '0;
    xy_step = '0; z_step = '0; aux_step = '0;

    // Reset state and identity rotation latency.
    step(2);
    check("rst_x", x_d, 0);
    check("rst_valid", xv, 0);
    check("rst_settled", settled_d, 0);
    a_rst = 1'b0;
    step(3);
    check("rot_x_before_lat", x_d, 0);
    step(1);
    check("rot_x", x_d, 1000);
    check("rot_y", y_d, -500);
    check("bias_u", u_d, -3);
    check("valid_t0p3", xv, 0);
    step(1);
    check("valid_t0p4", zv, 0);
    step(1);
    check("valid_t0p5", zv, 1);
    check("valid_aux_t0p5", auxv, 1);

    // Slew of x0 from 0 to 1050 at 100 per tick.
    check("x0_settled_pre", settled_d[0], 1);
    xy_step = 32'd100;
    x0 = 32'd1050;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("x0mon_slew", x0m, i * 100);
      check("x0_settled_slew", settled_d[0], 0);
    end
    step(1);
    check("x0mon_final", x0m, 1050);
    check("x0_settled_final", settled_d[0], 1);

    // Saturation; step bit31 must be ignored.
    x0 = 32'h7FFF_FFFF;
    z0 = -32'sd2147483647;
    xy_step = 32'hFFFF_FFFF;
    zs = -32'sd1000;
    step(1);
    check("x0mon_max", x0m, 64'sd2147483647);
    check("z0mon_min", z0m, -64'sd2147483647);
    step(6);
    check("sat_x_pos", x_d, 64'sd2147483647);
    check("sat_z_neg", z_d, -64'sd2147483647);
    check("sat_y_unaffected", y_d, -500);

    // Plane compensation with enable on, then off.
    a_rst = 1'b1;
    x0 = '0; y0 = '0; z0 = '0; xy_step = 32'd100;
    xs = 32'd4000; ys = '0; zs = 32'd300; zz = 32'd20; uu = '0; u0 = '0;
    slope_x = 32'd1 << 30; slope_y = '0; z_step = 32'h7FFF_FFFF; slope_en = 1'b1;
    step(1);
    a_rst = 1'b0;
    step(8);
    check("z_slope", zsl, 2000);
    check("z_with_slope", z_d, 2320);
    check("x_plain", x_d, 4000);
    check("all_settled", settled_d, 7'h7F);
    slope_en = 1'b0;
    step(6);
    check("z_no_slope", z_d, 320);
    check("z_slope_still", zsl, 2000);

    // Reset in the middle of an aux slew.
    aux_step = 32'd10;
    aux0 = {-32'sd50, 32'sd100};
    step(3);
    check("aux0_slew", $signed(aux_d[31:0]), 30);
    check("aux1_slew", $signed(aux_d[63:32]), -30);
    a_rst = 1'b1;
    step(1);
    check("mid_rst_x", x_d, 0);
    check("mid_rst_z", z_d, 0);
    check("mid_rst_aux", aux_d, 0);
    check("mid_rst_zslope", zsl, 0);
    check("mid_rst_valid", zv, 0);
    check("mid_rst_settled", settled_d, 0);
    a_rst = 1'b0;
    step(1);
    check("aux0_restart", $signed(aux_d[31:0]), 10);
    check("aux1_restart", $signed(aux_d[63:32]), -10);
    check("aux0_unsettled", settled_d[5], 0);

    // Decimation by 4 with a dropped sample on the second tick.
    a_rst = 1'b1;
    xs = 32'd1000; ys = '0; xs_v = 1'b1; x0 = '0;
    step(1);
    a_rst = 1'b0;
    step(1);
    xs = 32'd2000; xs_v = 1'b0;
    step(2);
    check("deci_x_before_lat", x_2, 0);
    step(1);
    check("deci_x_first", x_2, 1000);
    step(1);
    check("deci_x_hold_t2", x_2, 1000);
    check("deci_valid_t0p4", xv_2, 0);
    xs = 32'd3000; xs_v = 1'b1;
    step(1);
    check("deci_valid_t0p5", xv_2, 1);
    step(2);
    check("deci_x_held_invalid", x_2, 1000);
    step(3);
    check("deci_x_no_midtick", x_2, 1000);
    step(1);
    check("deci_x_update", x_2, 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
